ysyx_040750_ex_mem_reg: RTL and testbench

Pipeline register between the EX stage and the MEM stage. It is the receiving end of the ALU result handshake: it captures `I_result` when `I_result_valid` is high and it drives `O_EX_MEM_ready` back to the ALU. It then presents the captured instruction to MEM under a valid/ready handshake. It also exports forwarding and load-hazard information for the decode stage.

---
 rtl/ysyx_040750_ex_mem_reg.sv | 169 ++++++++++++++++
 tb/tb_ysyx_040750_ex_mem_reg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_040750_ex_mem_reg.sv
// EX/MEM pipeline register: captures the ALU result and presents it to MEM with a valid/ready handshake.
// Latency 1 cycle (in_fire at edge N -> head valid in cycle N+1); throughput 1 entry/cycle while MEM is ready.
// Backpressure: the default build holds one entry, ready = ~O_valid | I_MEM_ready. With
// YSYX_040750_EXMEM_SKID_EN defined it holds two entries (EMPTY/ONE/FULL) and ready is registered (state != FULL).
module ysyx_040750_ex_mem_reg (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_flush,
  input  logic        I_ex_valid,
  input  logic [63:0] I_result,
  input  logic        I_result_valid,
  input  logic [4:0]  I_rd,
  input  logic        I_rd_wen,
  input  logic        I_mem_ren,
  input  logic        I_mem_wen,
  input  logic [2:0]  I_mem_size,
  input  logic [63:0] I_store_data,
  input  logic [63:0] I_pc,
  output logic        O_EX_MEM_ready,
  output logic        O_valid,
  input  logic        I_MEM_ready,
  output logic [63:0] O_result,
  output logic [4:0]  O_rd,
  output logic        O_rd_wen,
  output logic        O_mem_ren,
  output logic        O_mem_wen,
  output logic [2:0]  O_mem_size,
  output logic [63:0] O_store_data,
  output logic [63:0] O_pc,
  output logic        O_fwd_valid,
  output logic [4:0]  O_fwd_rd,
  output logic [63:0] O_fwd_data,
  output logic        O_load_hazard
);

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        mem_ren;
    logic        mem_wen;
    logic [2:0]  mem_size;
    logic [63:0] store_data;
    logic [63:0] pc;
  } entry_t;

  entry_t in_ent;
  entry_t head_q;
  logic   in_fire;
  logic   out_fire;

  // Assemble the incoming entry; a write to x0 is dropped at capture so it is never forwarded or written.
  always_comb begin
    in_ent            = '0;
    in_ent.result     = I_result;
    in_ent.rd         = I_rd;
    in_ent.rd_wen     = I_rd_wen & (I_rd != 5'd0);
    in_ent.mem_ren    = I_mem_ren;
    in_ent.mem_wen    = I_mem_wen;
    in_ent.mem_size   = I_mem_size;
    in_ent.store_data = I_store_data;
    in_ent.pc         = I_pc;
  end

  assign in_fire  = I_ex_valid & I_result_valid & O_EX_MEM_ready & ~I_flush;
  assign out_fire = O_valid & I_MEM_ready;

`ifdef YSYX_040750_EXMEM_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state_q;
  state_t state_d;
  entry_t skid_q;
  logic   load_head;
  logic   load_skid;
  logic   head_from_skid;

  assign O_valid        = (state_q != EMPTY);
  assign O_EX_MEM_ready = (state_q != FULL);

  // Occupancy state register.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next occupancy and slot-load controls; flush empties the buffer and ignores MEM that cycle.
  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    load_skid      = 1'b0;
    head_from_skid = 1'b0;
    if (I_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = ONE;
            load_head = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_head = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d        = ONE;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Head and skid slots; each entry is written once and then held unchanged until it leaves.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_head)           head_q <= in_ent;
      else if (head_from_skid) head_q <= skid_q;
      if (load_skid)           skid_q <= in_ent;
    end
  end
`else
  logic valid_q;

  assign O_valid        = valid_q;
  assign O_EX_MEM_ready = ~valid_q | I_MEM_ready;

  // Single-entry occupancy: flush wins, then capture, then drain.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst)         valid_q <= 1'b0;
    else if (I_flush)  valid_q <= 1'b0;
    else if (in_fire)  valid_q <= 1'b1;
    else if (out_fire) valid_q <= 1'b0;
  end

  // Head entry is replaced only on capture.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst)        head_q <= '0;
    else if (in_fire) head_q <= in_ent;
  end
`endif

  assign O_result      = head_q.result;
  assign O_rd          = head_q.rd;
  assign O_rd_wen      = head_q.rd_wen;
  assign O_mem_ren     = head_q.mem_ren;
  assign O_mem_wen     = head_q.mem_wen;
  assign O_mem_size    = head_q.mem_size;
  assign O_store_data  = head_q.store_data;
  assign O_pc          = head_q.pc;
  assign O_fwd_valid   = O_valid & head_q.rd_wen & ~head_q.mem_ren;
  assign O_fwd_rd      = head_q.rd;
  assign O_fwd_data    = head_q.result;
  assign O_load_hazard = O_valid & head_q.mem_ren & head_q.rd_wen;

endmodule

// File: tb/tb_ysyx_040750_ex_mem_reg.sv
// Bench for ysyx_040750_ex_mem_reg: directed scenarios plus random traffic against a queue model.
// The model is a FIFO of capacity 1 (default) or 2 (YSYX_040750_EXMEM_SKID_EN).
module tb_ysyx_040750_ex_mem_reg;
  logic        clk = 1'b0;
  logic        rst, flush, ex_valid, result_valid, rd_wen, mem_ren, mem_wen, mem_ready;
  logic [63:0] result, store_data, pc;
  logic [4:0]  rd;
  logic [2:0]  mem_size;
  logic        o_ready, o_valid, o_rd_wen, o_mem_ren, o_mem_wen, o_fwd_valid, o_load_hazard;
  logic [63:0] o_result, o_store_data, o_pc, o_fwd_data;
  logic [4:0]  o_rd, o_fwd_rd;
  logic [2:0]  o_mem_size;

  always #5 clk = ~clk;

  ysyx_040750_ex_mem_reg dut (
    .I_sys_clk(clk), .I_rst(rst), .I_flush(flush), .I_ex_valid(ex_valid),
    .I_result(result), .I_result_valid(result_valid), .I_rd(rd), .I_rd_wen(rd_wen),
    .I_mem_ren(mem_ren), .I_mem_wen(mem_wen), .I_mem_size(mem_size),
    .I_store_data(store_data), .I_pc(pc), .O_EX_MEM_ready(o_ready), .O_valid(o_valid),
    .I_MEM_ready(mem_ready), .O_result(o_result), .O_rd(o_rd), .O_rd_wen(o_rd_wen),
    .O_mem_ren(o_mem_ren), .O_mem_wen(o_mem_wen), .O_mem_size(o_mem_size),
    .O_store_data(o_store_data), .O_pc(o_pc), .O_fwd_valid(o_fwd_valid),
    .O_fwd_rd(o_fwd_rd), .O_fwd_data(o_fwd_data), .O_load_hazard(o_load_hazard)
  );

`ifdef YSYX_040750_EXMEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [63:0] result, store_data, pc;
    logic [4:0]  rd;
    logic        rd_wen, mem_ren, mem_wen;
    logic [2:0]  size;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic exp_ready();
    if (CAP == 1) return (q.size() == 0) || mem_ready;
    return q.size() < CAP;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    ent_t h;
    chk("valid", o_valid, q.size() != 0);
    chk("ready", o_ready, exp_ready());
    if (q.size() != 0) begin
      h = q[0];
      chk("result", o_result, h.result);
      chk("rd", o_rd, h.rd);
      chk("rd_wen", o_rd_wen, h.rd_wen);
      chk("mem_ren", o_mem_ren, h.mem_ren);
      chk("mem_wen", o_mem_wen, h.mem_wen);
      chk("mem_size", o_mem_size, h.size);
      chk("store_data", o_store_data, h.store_data);
      chk("pc", o_pc, h.pc);
      chk("fwd_valid", o_fwd_valid, h.rd_wen & ~h.mem_ren);
      chk("fwd_rd", o_fwd_rd, h.rd);
      chk("fwd_data", o_fwd_data, h.result);
      chk("load_hazard", o_load_hazard, h.mem_ren & h.rd_wen);
    end else begin
      chk("fwd_valid_empty", o_fwd_valid, 0);
      chk("load_hazard_empty", o_load_hazard, 0);
    end
  endtask

  task automatic check_zero();
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_result", o_result, 0);
    chk("rst_rd", o_rd, 0);
    chk("rst_flags", {o_rd_wen, o_mem_ren, o_mem_wen, o_fwd_valid, o_load_hazard}, 0);
    chk("rst_size", o_mem_size, 0);
    chk("rst_store", o_store_data, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_fwd", {o_fwd_rd, o_fwd_data}, 0);
  endtask

  // Called just after a falling edge with inputs already driven: check, clock, update model.
  task automatic step();
    logic inf, outf;
    ent_t e;
    #1 check_outputs();
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
    end else begin
      inf  = ex_valid && result_valid && exp_ready();
      outf = (q.size() != 0) && mem_ready;
      if (outf) void'(q.pop_front());
      if (inf) begin
        e.result = result; e.store_data = store_data; e.pc = pc; e.rd = rd;
        e.rd_wen = rd_wen && (rd != 5'd0); e.mem_ren = mem_ren; e.mem_wen = mem_wen;
        e.size = mem_size;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic ev, input logic rv, input logic [63:0] res, input logic [4:0] r,
                       input logic w, input logic ren, input logic mwen);
    ex_valid = ev; result_valid = rv; result = res; rd = r; rd_wen = w;
    mem_ren = ren; mem_wen = mwen;
    mem_size = 3'($urandom_range(0, 7));
    store_data = {$urandom, $urandom};
    pc = {32'h0, $urandom} & 64'hFFFF_FFFC;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  int rises;
  logic prev_v;

  initial begin
    rst = 1; flush = 0; mem_ready = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step(); step();
    rst = 0;
    #1 check_zero();
    @(negedge clk);

    // Back-to-back adds with MEM always ready.
    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 64'(i), 5'(i), 1, 0, 0);
      step();
      chk("b2b_head", o_result, 64'(i));
      chk("b2b_ready", o_ready, 1);
    end
    idle(2);

    // Load captured, then MEM stalls while 0x20 is offered.
    drive(1, 1, 64'h8000_0010, 5'd5, 1, 1, 0);
    step();
    mem_ready = 0;
    drive(1, 1, 64'h20, 5'd6, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_head", o_result, 64'h8000_0010);
      chk("bp_load_hazard", o_load_hazard, 1);
    end
    chk("bp_ready", o_ready, 0);
    mem_ready = 1;
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("bp_second", o_result, 64'h20);
    idle(2);

    // Multicycle op: result not valid for 30 cycles.
    rises = 0; prev_v = o_valid;
    drive(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 1, 0, 0);
    for (int i = 0; i < 30; i++) begin
      step();
      chk("mc_no_capture", o_valid, 0);
    end
    result_valid = 1;
    step();
    ex_valid = 0; result_valid = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_valid && !prev_v) rises++;
      prev_v = o_valid;
      step();
    end
    chk("mc_rises", rises, 1);

    // x0 suppression, then a real destination.
    drive(1, 1, 64'h55, 5'd0, 1, 0, 0);
    step();
    chk("x0_rd_wen", o_rd_wen, 0);
    chk("x0_fwd_valid", o_fwd_valid, 0);
    drive(1, 1, 64'h55, 5'd7, 1, 0, 0);
    step();
    chk("x7_fwd_valid", o_fwd_valid, 1);
    chk("x7_fwd_rd", o_fwd_rd, 7);
    chk("x7_fwd_data", o_fwd_data, 64'h55);
    idle(2);

    // Fill under stall, then flush together with a capture candidate 0xC.
    mem_ready = 0;
    drive(1, 1, 64'hA, 5'd1, 1, 0, 0);
    step();
    drive(1, 1, 64'hB, 5'd2, 1, 0, 0);
    step();
    drive(1, 1, 64'hC, 5'd3, 1, 0, 0);
    flush = 1;
    step();
    flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("flush_valid", o_valid, 0);
    chk("flush_ready", o_ready, 1);
    mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_c", o_valid, 0);
    end

    // Reset mid-operation with the buffer full.
    mem_ready = 0;
    drive(1, 1, 64'h111, 5'd4, 1, 1, 1);
    step(); step(); step();
    rst = 1;
    step();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 check_zero();
    @(negedge clk);
    mem_ready = 1;

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      mem_ready = $urandom_range(0, 4) < 3;
      flush = $urandom_range(0, 24) == 0;
      rst = $urandom_range(0, 99) == 0;
      step();
    end
    rst = 0; flush = 0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
